exe_div_seq: RTL and testbench
==============================

// Module: exe_div_seq
// PURPOSE
//  Multi-cycle sequencer and datapath for RV64M DIV/DIVU/REM/REMU and the W forms.
//  Sits beside the EXE-stage ALU. EXE issues one request and stalls on in_ready/out_valid.
//  The retired result is muxed onto the EXE alu_out path.
//  Iterative restoring division, BPC quotient bits per cycle; special cases bypass iteration.
// PARAMETERS
//  XLEN  64  operand/result width (ports are XLEN wide)
//  BPC   1   quotient bits per CALC cycle; legal 1,2,4; must divide 32
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     asynchronous reset, active-low (0 = reset)
//  flush      in   1     EXE flush; abandons any operation in flight
//  in_valid   in   1     request valid
//  in_ready   out  1     unit can accept a request (state IDLE)
//  funct3     in   3     100 DIV, 101 DIVU, 110 REM, 111 REMU
//  word32     in   1     1 = W form (32-bit operation, 64-bit sign-extended result)
//  rs1        in   XLEN  dividend
//  rs2        in   XLEN  divisor
//  out_valid  out  1     result valid (state DONE)
//  out_ack    in   1     EXE consumed result
//  result     out  XLEN  quotient or remainder
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, result=0, all internal regs 0.
//  FSM states: IDLE, CALC, FIX, DONE.
//   IDLE: in_valid&&in_ready latches funct3, word32 and operands (accept cycle T).
//         Divisor==0 or signed overflow -> DONE (out_valid at T+1); else -> CALC.
//   CALC: ITER = W/BPC cycles; W = 32 if word32 else 64. Iteration counter counts down.
//         -> FIX when the counter reaches 0.
//   FIX:  one cycle; applies sign correction and W-form sign extension -> DONE.
//         Normal latency: out_valid first high at T+ITER+2 (T+66 for 64-bit, T+34 for W, BPC=1).
//   DONE: out_valid=1; result held stable until out_ack; out_ack -> IDLE.
//         No new request is accepted in the ack cycle (in_ready=0 in DONE).
//  Operand preparation (at accept):
//   - W forms use rs1[31:0]/rs2[31:0], sign- or zero-extended per funct3[0].
//   - Signed ops divide magnitudes. Quotient negated if operand signs differ.
//     Remainder takes the dividend sign.
//  Special cases (RISC-V spec values, computed on the effective width W):
//   - Divisor 0: quotient all-ones; remainder = dividend.
//   - Signed overflow (dividend = -2^(W-1), divisor = -1): quotient = dividend; remainder 0.
//   - W results: result = sign-extension of the 32-bit value, including DIVUW/REMUW.
//  flush: any state -> IDLE next edge; out_valid=0; in_ready=1 next cycle.
//   flush has priority over in_valid and out_ack in the same cycle (request not accepted).
//  Async reset mid-operation: immediate return to reset values; no residual out_valid.
//  in_valid outside IDLE is ignored; EXE holds the request until in_ready.
//  result is only meaningful while out_valid=1; it is 0 after reset and is not cleared by flush.
// TESTING
//  1 DIVU rs1=100, rs2=7, BPC=1: accept at T -> out_valid at T+66, result=14.
//    Hold out_ack=0 for 3 cycles: result stays 14; ack -> in_ready=1 next cycle.
//  2 REM rs1=-7, rs2=2 -> result=0xFFFF_FFFF_FFFF_FFFF (-1).
//    DIV rs1=-7, rs2=2 -> 0xFFFF_FFFF_FFFF_FFFD (-3).
//  3 DIVU rs1=5, rs2=0 -> out_valid at T+1, result=all-ones. REMU same operands -> 5.
//  4 DIVW rs1=0x0000_0000_8000_0000, rs2=0xFFFF_FFFF_FFFF_FFFF -> T+1, result=0xFFFF_FFFF_8000_0000.
//    REMW same operands -> 0.
//    DIVUW rs1=0xFFFF_FFFF, rs2=1 -> T+34, result=0xFFFF_FFFF_FFFF_FFFF.
//  5 Assert flush during CALC cycle 10 -> out_valid never rises; in_ready=1 next cycle.
//    Next DIVU 9/3 -> 3 at normal latency.
//    Assert flush and out_ack together in DONE -> IDLE; no new accept that cycle.
//  6 Drive rst low mid-CALC -> outputs at reset values immediately.
//    Release rst; back-to-back requests with random operands match the reference model.
//    Run with BPC=1,2,4.

Source files
------------

// File: rtl/exe_div_seq_if.sv
// Request/response bundle between the EXE stage and the divide sequencer.
//   master (EXE side):  drives in_valid, funct3, word32, rs1, rs2, out_ack
//   slave  (divider):   drives in_ready, out_valid, result
interface exe_div_seq_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic            word32;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            out_valid;
  logic            out_ack;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, funct3, word32, rs1, rs2, out_ack,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, funct3, word32, rs1, rs2, out_ack,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/exe_div_seq.sv
// Multi-cycle RV64M divider (DIV/DIVU/REM/REMU and W forms) beside the EXE ALU.
// Iterative restoring division on operand magnitudes, BPC quotient bits per
// CALC cycle; divide-by-zero and signed overflow bypass the iteration.
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active low
//   flush : abandons any operation in flight, returns to IDLE
//   bus   : request/response bundle (slave side)
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// CALC  | restoring-division iterations, counter counts down to 0
// FIX   | sign correction and W-form sign extension of the result
// DONE  | out_valid=1, result held until out_ack
module exe_div_seq #(
  parameter int XLEN = 64,
  parameter int BPC  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  exe_div_seq_if.slave bus
);

  localparam int ITER_D = XLEN / BPC;
  localparam int ITER_W = 32 / BPC;
  localparam int CNT_W  = $clog2(ITER_D + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD_D = CNT_W'(ITER_D - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD_W = CNT_W'(ITER_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   div_q, div_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              word_q, word_d;
  logic              rem_op_q, rem_op_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  // Operand preparation on the effective width.
  logic            is_signed;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_res, min_eff, special_res;
  logic            a_neg, b_neg, div_zero, ovf;

  always_comb begin
    is_signed = ~bus.funct3[0];
    if (bus.word32) begin
      a_ext   = is_signed ? sext32(bus.rs1[31:0]) : {{(XLEN-32){1'b0}}, bus.rs1[31:0]};
      b_ext   = is_signed ? sext32(bus.rs2[31:0]) : {{(XLEN-32){1'b0}}, bus.rs2[31:0]};
      a_res   = sext32(bus.rs1[31:0]);
      min_eff = sext32(32'h8000_0000);
    end else begin
      a_ext   = bus.rs1;
      b_ext   = bus.rs2;
      a_res   = bus.rs1;
      min_eff = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg    = is_signed & a_ext[XLEN-1];
    b_neg    = is_signed & b_ext[XLEN-1];
    a_mag    = a_neg ? (~a_ext + 1'b1) : a_ext;
    b_mag    = b_neg ? (~b_ext + 1'b1) : b_ext;
    div_zero = (b_ext == '0);
    ovf      = is_signed & (a_ext == min_eff) & (&b_ext);
    // Divide by zero: q = all ones, r = dividend. Overflow: q = dividend, r = 0.
    if (div_zero) special_res = bus.funct3[1] ? a_res : '1;
    else          special_res = bus.funct3[1] ? '0    : a_res;
  end

  // BPC restoring steps per cycle. The dividend is left-aligned in quo_q so the
  // next dividend bit is always the MSB; quotient bits shift in at the LSB.
  logic [XLEN-1:0] step_rem, step_quo;
  logic [XLEN:0]   step_sh, step_diff;

  always_comb begin
    step_rem  = rem_q;
    step_quo  = quo_q;
    step_sh   = '0;
    step_diff = '0;
    for (int i = 0; i < BPC; i++) begin
      step_sh   = {step_rem, step_quo[XLEN-1]};
      step_diff = step_sh - {1'b0, div_q};
      // Borrow out of bit XLEN means the partial remainder is below the divisor.
      step_quo  = {step_quo[XLEN-2:0], ~step_diff[XLEN]};
      step_rem  = step_diff[XLEN] ? step_sh[XLEN-1:0] : step_diff[XLEN-1:0];
    end
  end

  logic [XLEN-1:0] fix_quo, fix_rem, fix_sel, fix_res;

  always_comb begin
    fix_quo = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    fix_rem = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    fix_sel = rem_op_q ? fix_rem : fix_quo;
    fix_res = word_q ? sext32(fix_sel[31:0]) : fix_sel;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    result_d  = result_q;
    word_d    = word_q;
    rem_op_d  = rem_op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          word_d    = bus.word32;
          rem_op_d  = bus.funct3[1];
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div_d     = b_mag;
          rem_d     = '0;
          quo_d     = bus.word32 ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
          cnt_d     = bus.word32 ? CNT_LOAD_W : CNT_LOAD_D;
          if (div_zero || ovf) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Flush wins over accept and ack; a request seen in the same cycle is dropped
    // and the previous result stays put.
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      result_q  <= '0;
      word_q    <= 1'b0;
      rem_op_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      result_q  <= result_d;
      word_q    <= word_d;
      rem_op_q  <= rem_op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;

endmodule

// File: tb/tb_exe_div_seq.sv
module tb_exe_div_seq;
  localparam int XLEN   = 64;
  localparam int TB_BPC = 1;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;

  exe_div_seq_if #(.XLEN(XLEN)) bus ();

  exe_div_seq #(.XLEN(XLEN), .BPC(TB_BPC)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference values straight from the RISC-V M-extension definition.
  function automatic logic [63:0] ref_div(input logic [2:0] f3, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [31:0] sa32, sb32;
    logic signed [63:0] sa, sb;
    logic [31:0] r32;
    logic [63:0] r;
    sa32 = a[31:0];
    sb32 = b[31:0];
    sa   = a;
    sb   = b;
    if (w) begin
      case (f3[1:0])
        2'b00: begin
          if (b[31:0] == 32'd0) r32 = 32'hFFFF_FFFF;
          else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = a[31:0];
          else r32 = sa32 / sb32;
        end
        2'b01: begin
          if (b[31:0] == 32'd0) r32 = 32'hFFFF_FFFF;
          else r32 = a[31:0] / b[31:0];
        end
        2'b10: begin
          if (b[31:0] == 32'd0) r32 = a[31:0];
          else if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = 32'd0;
          else r32 = sa32 % sb32;
        end
        default: begin
          if (b[31:0] == 32'd0) r32 = a[31:0];
          else r32 = a[31:0] % b[31:0];
        end
      endcase
      return {{32{r32[31]}}, r32};
    end
    case (f3[1:0])
      2'b00: begin
        if (b == 64'd0) r = '1;
        else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
        else r = sa / sb;
      end
      2'b01: begin
        if (b == 64'd0) r = '1;
        else r = a / b;
      end
      2'b10: begin
        if (b == 64'd0) r = a;
        else if (a == 64'h8000_0000_0000_0000 && b == '1) r = 64'd0;
        else r = sa % sb;
      end
      default: begin
        if (b == 64'd0) r = a;
        else r = a % b;
      end
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic zero, ov;
    if (w) begin
      zero = (b[31:0] == 32'd0);
      ov   = !f3[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF;
    end else begin
      zero = (b == 64'd0);
      ov   = !f3[0] && a == 64'h8000_0000_0000_0000 && b == '1;
    end
    if (zero || ov) return 1;
    return (w ? 32 : 64) / TB_BPC + 2;
  endfunction

  // Called at a negedge with the unit idle or about to be idle. Ends at a
  // negedge after the ack has been taken.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_res, input int exp_lat, input int hold);
    int n;
    bus.funct3   = f3;
    bus.word32   = w;
    bus.rs1      = a;
    bus.rs2      = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check($sformatf("%s accept_timeout", tag), 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s latency", tag), 64'(n), 64'(exp_lat));
    if (!bus.out_valid) return;
    check($sformatf("%s result", tag), bus.result, exp_res);
    check($sformatf("%s in_ready_in_done", tag), 64'(bus.in_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check($sformatf("%s hold_valid", tag), 64'(bus.out_valid), 64'd1);
      check($sformatf("%s hold_result", tag), bus.result, exp_res);
    end
    bus.out_ack = 1'b1;
    @(negedge clk);
    bus.out_ack = 1'b0;
    check($sformatf("%s ready_after_ack", tag), 64'(bus.in_ready), 64'd1);
    check($sformatf("%s valid_after_ack", tag), 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic        seen;
    logic [31:0] r;
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a, b;

    bus.in_valid = 1'b0;
    bus.funct3   = 3'b100;
    bus.word32   = 1'b0;
    bus.rs1      = '0;
    bus.rs2      = '0;
    bus.out_ack  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst in_ready", 64'(bus.in_ready), 64'd1);
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst result", bus.result, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst in_ready", 64'(bus.in_ready), 64'd1);

    do_op("divu_100_7", 3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 66, 3);
    do_op("rem_m7_2", 3'b110, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
    do_op("div_m7_2", 3'b100, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0);
    do_op("divu_by0", 3'b101, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1);
    do_op("remu_by0", 3'b111, 1'b0, 64'd5, 64'd0, 64'd5, 1, 0);
    do_op("divw_ovf", 3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000, 1, 0);
    do_op("remw_ovf", 3'b110, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'd0, 1, 0);
    do_op("divuw_ff_1", 3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1,
          64'hFFFF_FFFF_FFFF_FFFF, 34, 0);
    do_op("div_ovf64", 3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 1, 0);

    // Flush in CALC cycle 10.
    bus.funct3 = 3'b101; bus.word32 = 1'b0; bus.rs1 = 64'd1000; bus.rs2 = 64'd3;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("calc busy in_ready", 64'(bus.in_ready), 64'd0);
    check("calc busy out_valid", 64'(bus.out_valid), 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_calc in_ready", 64'(bus.in_ready), 64'd1);
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("flush_calc no_out_valid", 64'(seen), 64'd0);

    do_op("divu_9_3", 3'b101, 1'b0, 64'd9, 64'd3, 64'd3, 66, 0);

    // Flush together with a request in IDLE: the request must be dropped.
    bus.funct3 = 3'b101; bus.word32 = 1'b0; bus.rs1 = 64'd5; bus.rs2 = 64'd0;
    bus.in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_idle in_ready", 64'(bus.in_ready), 64'd1);
    check("flush_idle out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_idle result_kept", bus.result, 64'd3);

    // Flush and ack together in DONE.
    bus.funct3 = 3'b101; bus.rs1 = 64'd5; bus.rs2 = 64'd0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("done reached", 64'(bus.out_valid), 64'd1);
    flush = 1'b1;
    bus.out_ack = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.out_ack = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_ack in_ready", 64'(bus.in_ready), 64'd1);
    check("flush_ack out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("flush_ack no_accept", 64'(bus.in_ready), 64'd1);

    // Async reset mid-CALC.
    bus.funct3 = 3'b101; bus.word32 = 1'b0; bus.rs1 = 64'd1000; bus.rs2 = 64'd3;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_arst busy", 64'(bus.in_ready), 64'd0);
    #2 rst = 1'b0;
    #1;
    check("arst in_ready", 64'(bus.in_ready), 64'd1);
    check("arst out_valid", 64'(bus.out_valid), 64'd0);
    check("arst result", bus.result, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("arst_release in_ready", 64'(bus.in_ready), 64'd1);

    for (int k = 0; k < 16; k++) begin
      r  = $urandom;
      f3 = {1'b1, r[1:0]};
      w  = r[2];
      a  = {$urandom, $urandom};
      case (r[5:3])
        3'd0: b = 64'd0;
        3'd1: begin
          b = '1;
          if (w) a[31:0] = 32'h8000_0000;
          else   a = 64'h8000_0000_0000_0000;
        end
        3'd2: b = 64'($urandom_range(1, 20));
        3'd3: b = -64'($urandom_range(1, 20));
        default: b = {$urandom, $urandom} >> $urandom_range(0, 60);
      endcase
      do_op($sformatf("rnd%0d", k), f3, w, a, b, ref_div(f3, w, a, b),
            ref_lat(f3, w, a, b), int'(r[7:6]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
